// File: rtl/clock_pkg.sv
// Shared types and helpers for the MainClock adjust-key controller.
// Optional auto-repeat is selected by CLOCK_ADJ_AUTOREPEAT_EN (see clock_adj_key_fsm).
package clock_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DEB_P  = 3'd1,
        HELD   = 3'd2,
        REPEAT = 3'd3,
        DEB_R  = 3'd4
    } key_state_t;

    localparam logic TGT_TIME  = 1'b0;
    localparam logic TGT_ALARM = 1'b1;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return ($clog2(max_val + 1) < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/clock_adj_key_fsm.sv
// One adjust key: 2-flop synchroniser, press/release debounce, hold/auto-repeat and a
// one-deep pending request flag. Auto-repeat is built only when CLOCK_ADJ_AUTOREPEAT_EN is defined.
module clock_adj_key_fsm
    import clock_pkg::*;
#(
    parameter int DEB_MS  = 20,
    parameter int HOLD_MS = 600,
    parameter int REP_MS  = 200
) (
    input  logic       CP50,
    input  logic       nCR,
    input  logic       tick_ms,
    input  logic       i_key,
    input  logic       i_tgt,
    input  logic       i_grant,
    output logic       o_pend,
    output logic       o_tgt,
    output key_state_t o_state
);

    localparam int MAX_DH = (DEB_MS > HOLD_MS) ? DEB_MS : HOLD_MS;
    localparam int MAX_P  = (MAX_DH > REP_MS) ? MAX_DH : REP_MS;
    localparam int CW     = cnt_width(MAX_P);

    logic [1:0]    r_sync;
    key_state_t    r_state;
    key_state_t    r_ret;
    logic [CW-1:0] r_deb;
    logic          r_tgt;
    logic          r_pend;
`ifdef CLOCK_ADJ_AUTOREPEAT_EN
    logic [CW-1:0] r_cnt;
`endif
    logic          w_key;

    assign w_key   = r_sync[1];
    assign o_pend  = r_pend;
    assign o_tgt   = r_tgt;
    assign o_state = r_state;

    // The pending flag is cleared by a grant, but a request in the same cycle wins so it is not lost.
    always_ff @(posedge CP50 or negedge nCR) begin
        if (!nCR) begin
            r_sync  <= 2'b00;
            r_state <= IDLE;
            r_ret   <= HELD;
            r_deb   <= '0;
            r_tgt   <= TGT_TIME;
            r_pend  <= 1'b0;
`ifdef CLOCK_ADJ_AUTOREPEAT_EN
            r_cnt   <= '0;
`endif
        end else begin
            r_sync <= {r_sync[0], i_key};
            if (i_grant) begin
                r_pend <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (w_key) begin
                        r_state <= DEB_P;
                        r_deb   <= '0;
                    end
                end
                DEB_P: begin
                    if (!w_key) begin
                        r_state <= IDLE;
                    end else if (tick_ms) begin
                        if (r_deb == CW'(DEB_MS - 1)) begin
                            r_state <= HELD;
                            r_tgt   <= i_tgt;
                            r_pend  <= 1'b1;
`ifdef CLOCK_ADJ_AUTOREPEAT_EN
                            r_cnt   <= '0;
`endif
                        end else begin
                            r_deb <= r_deb + 1'b1;
                        end
                    end
                end
                HELD: begin
                    if (!w_key) begin
                        r_state <= DEB_R;
                        r_ret   <= HELD;
                        r_deb   <= '0;
                    end
`ifdef CLOCK_ADJ_AUTOREPEAT_EN
                    else if (tick_ms) begin
                        if (r_cnt == CW'(HOLD_MS - 1)) begin
                            r_state <= REPEAT;
                            r_pend  <= 1'b1;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
`endif
                end
`ifdef CLOCK_ADJ_AUTOREPEAT_EN
                REPEAT: begin
                    if (!w_key) begin
                        r_state <= DEB_R;
                        r_ret   <= REPEAT;
                        r_deb   <= '0;
                    end else if (tick_ms) begin
                        if (r_cnt == CW'(REP_MS - 1)) begin
                            r_pend <= 1'b1;
                            r_cnt  <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
`endif
                DEB_R: begin
                    // A bounce back to 1 resumes the hold/repeat timing where it left off.
                    if (w_key) begin
                        r_state <= r_ret;
                    end else if (tick_ms) begin
                        if (r_deb == CW'(DEB_MS - 1)) begin
                            r_state <= IDLE;
                        end else begin
                            r_deb <= r_deb + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/clock_adj_ctrl.sv
// Adjust-key controller: two key FSMs, hour-priority arbiter, target mapping and run_en gating.
// Build with CLOCK_ADJ_AUTOREPEAT_EN defined to enable auto-repeat while a key is held.
module clock_adj_ctrl
    import clock_pkg::*;
#(
    parameter int DEB_MS  = 20,
    parameter int HOLD_MS = 600,
    parameter int REP_MS  = 200
) (
    input  logic CP50,
    input  logic nCR,
    input  logic tick_ms,
    input  logic EN,
    input  logic DisplayA,
    input  logic AdjH,
    input  logic AdjM,
    output logic time_inc_h,
    output logic time_inc_m,
    output logic alarm_inc_h,
    output logic alarm_inc_m,
    output logic sec_clr,
    output logic run_en,
    output logic adj_busy
);

    logic       w_pend_h, w_pend_m;
    logic       w_tgt_h, w_tgt_m;
    logic       w_grant_h, w_grant_m;
    logic       w_adj_time_h, w_adj_time_m;
    key_state_t w_state_h, w_state_m;

    logic r_time_inc_h, r_time_inc_m, r_alarm_inc_h, r_alarm_inc_m, r_sec_clr;

    clock_adj_key_fsm #(
        .DEB_MS (DEB_MS),
        .HOLD_MS(HOLD_MS),
        .REP_MS (REP_MS)
    ) u_key_h (
        .CP50   (CP50),
        .nCR    (nCR),
        .tick_ms(tick_ms),
        .i_key  (AdjH),
        .i_tgt  (DisplayA),
        .i_grant(w_grant_h),
        .o_pend (w_pend_h),
        .o_tgt  (w_tgt_h),
        .o_state(w_state_h)
    );

    clock_adj_key_fsm #(
        .DEB_MS (DEB_MS),
        .HOLD_MS(HOLD_MS),
        .REP_MS (REP_MS)
    ) u_key_m (
        .CP50   (CP50),
        .nCR    (nCR),
        .tick_ms(tick_ms),
        .i_key  (AdjM),
        .i_tgt  (DisplayA),
        .i_grant(w_grant_m),
        .o_pend (w_pend_m),
        .o_tgt  (w_tgt_m),
        .o_state(w_state_m)
    );

    // Hour wins; a waiting minute request issues the cycle after the hour pulse.
    assign w_grant_h = w_pend_h;
    assign w_grant_m = w_pend_m & ~w_pend_h;

    always_ff @(posedge CP50 or negedge nCR) begin
        if (!nCR) begin
            r_time_inc_h  <= 1'b0;
            r_time_inc_m  <= 1'b0;
            r_alarm_inc_h <= 1'b0;
            r_alarm_inc_m <= 1'b0;
            r_sec_clr     <= 1'b0;
        end else begin
            r_time_inc_h  <= w_grant_h & (w_tgt_h == TGT_TIME);
            r_alarm_inc_h <= w_grant_h & (w_tgt_h == TGT_ALARM);
            r_time_inc_m  <= w_grant_m & (w_tgt_m == TGT_TIME);
            r_sec_clr     <= w_grant_m & (w_tgt_m == TGT_TIME);
            r_alarm_inc_m <= w_grant_m & (w_tgt_m == TGT_ALARM);
        end
    end

    assign time_inc_h  = r_time_inc_h;
    assign time_inc_m  = r_time_inc_m;
    assign alarm_inc_h = r_alarm_inc_h;
    assign alarm_inc_m = r_alarm_inc_m;
    assign sec_clr     = r_sec_clr;

    assign w_adj_time_h = (w_state_h inside {HELD, REPEAT, DEB_R}) && (w_tgt_h == TGT_TIME);
    assign w_adj_time_m = (w_state_m inside {HELD, REPEAT, DEB_R}) && (w_tgt_m == TGT_TIME);

    assign run_en   = EN & ~(w_adj_time_h | w_adj_time_m);
    assign adj_busy = (w_state_h != IDLE) | (w_state_m != IDLE);

endmodule

// File: tb/tb_clock_adj_ctrl.sv
// Self-checking bench for clock_adj_ctrl with DEB_MS=4, HOLD_MS=10, REP_MS=5 and tick_ms every 2nd cycle.
// The pulse model follows CLOCK_ADJ_AUTOREPEAT_EN when the bench is compiled with it.
module tb_clock_adj_ctrl;

  localparam int DEB_MS  = 4;
  localparam int HOLD_MS = 10;
  localparam int REP_MS  = 5;

  logic CP50 = 1'b0;
  logic nCR = 1'b0;
  logic tick_ms = 1'b0;
  logic EN = 1'b1;
  logic DisplayA = 1'b0;
  logic AdjH = 1'b0;
  logic AdjM = 1'b0;
  logic time_inc_h, time_inc_m, alarm_inc_h, alarm_inc_m, sec_clr, run_en, adj_busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int tick_n = 0;
  int viol = 0;
  int run_en_low = 0;
  logic tick_cont = 1'b0;
  bit autorep = 1'b0;

  // Pulse codes: 0 time_inc_h, 1 time_inc_m, 2 alarm_inc_h, 3 alarm_inc_m
  logic [1:0] exp_q[$];
  logic [1:0] obs_q[$];
  int obs_cyc_q[$];
  int obs_tick_q[$];

  clock_adj_ctrl #(
    .DEB_MS (DEB_MS),
    .HOLD_MS(HOLD_MS),
    .REP_MS (REP_MS)
  ) dut (
    .CP50       (CP50),
    .nCR        (nCR),
    .tick_ms    (tick_ms),
    .EN         (EN),
    .DisplayA   (DisplayA),
    .AdjH       (AdjH),
    .AdjM       (AdjM),
    .time_inc_h (time_inc_h),
    .time_inc_m (time_inc_m),
    .alarm_inc_h(alarm_inc_h),
    .alarm_inc_m(alarm_inc_m),
    .sec_clr    (sec_clr),
    .run_en     (run_en),
    .adj_busy   (adj_busy)
  );

  // ---------------- clock / reset / tick ----------------
  always #5 CP50 = ~CP50;

  always @(negedge CP50) tick_ms = tick_cont ? 1'b1 : ~tick_ms;

  always @(posedge CP50) begin
    cyc++;
    if (tick_ms) tick_n++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- monitor (samples on falling edge) ----------------
  always @(negedge CP50) begin
    int n;
    n = int'(time_inc_h) + int'(time_inc_m) + int'(alarm_inc_h) + int'(alarm_inc_m);
    if (n > 1 || sec_clr !== time_inc_m) viol++;
    if (time_inc_h)  begin obs_q.push_back(2'd0); obs_cyc_q.push_back(cyc); obs_tick_q.push_back(tick_n); end
    if (time_inc_m)  begin obs_q.push_back(2'd1); obs_cyc_q.push_back(cyc); obs_tick_q.push_back(tick_n); end
    if (alarm_inc_h) begin obs_q.push_back(2'd2); obs_cyc_q.push_back(cyc); obs_tick_q.push_back(tick_n); end
    if (alarm_inc_m) begin obs_q.push_back(2'd3); obs_cyc_q.push_back(cyc); obs_tick_q.push_back(tick_n); end
    if (!run_en && EN) run_en_low++;
  end

  // ---------------- reference model ----------------
  // Pulses produced by one clean press whose key is seen for t ticks.
  function automatic int exp_pulses(input int t);
    if (t < DEB_MS) return 0;
    if (!autorep || t < DEB_MS + HOLD_MS) return 1;
    return 2 + (t - DEB_MS - HOLD_MS) / REP_MS;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_obs();
    obs_q.delete();
    obs_cyc_q.delete();
    obs_tick_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_ticks(input int n);
    int k = 0;
    while (k < n) begin
      @(posedge CP50);
      if (tick_ms) k++;
    end
  endtask

  // Returns at a falling edge such that the next rising edge carries no tick.
  task automatic align();
    @(posedge CP50);
    while (!tick_ms) @(posedge CP50);
    @(negedge CP50);
  endtask

  task automatic press(input bit h, input bit m, input int ticks);
    align();
    AdjH = h;
    AdjM = m;
    wait_ticks(ticks);
    @(negedge CP50);
    AdjH = 1'b0;
    AdjM = 1'b0;
  endtask

  task automatic settle();
    int k = 0;
    wait_ticks(DEB_MS + 4);
    while (adj_busy && k < 200) begin
      @(negedge CP50);
      k++;
    end
    @(negedge CP50);
    if (adj_busy) begin
      checks++;
      errors++;
      $display("FAIL settle_timeout: adj_busy=%b after %0d cycles, want 0", adj_busy, k);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    nCR = 1'b0;
    EN = 1'b1;
    repeat (3) @(negedge CP50);
    checks++;
    if ({time_inc_h, time_inc_m, alarm_inc_h, alarm_inc_m, sec_clr} !== 5'b0) begin
      errors++;
      $display("FAIL reset_pulses: got %b want 00000",
               {time_inc_h, time_inc_m, alarm_inc_h, alarm_inc_m, sec_clr});
    end
    checks++;
    if (adj_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", adj_busy); end
    checks++;
    if (run_en !== 1'b1) begin errors++; $display("FAIL reset_run_en_en1: got %b want 1", run_en); end
    EN = 1'b0;
    #1;
    checks++;
    if (run_en !== 1'b0) begin errors++; $display("FAIL reset_run_en_en0: got %b want 0", run_en); end
    EN = 1'b1;
    @(negedge CP50);
    nCR = 1'b1;
    repeat (4) @(negedge CP50);
  endtask

  task automatic test_bounce();
    clear_obs();
    DisplayA = 1'b0;
    run_en_low = 0;
    press(1'b0, 1'b1, 3);
    settle();
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL bounce_pulses: got %0d want 0", obs_q.size()); end
    checks++;
    if (run_en_low != 0) begin errors++; $display("FAIL bounce_run_en: low for %0d cycles want 0", run_en_low); end
  endtask

  task automatic test_hold_single();
    int t0;
    clear_obs();
    DisplayA = 1'b0;
    align();
    AdjH = 1'b1;
    t0 = tick_n;
    wait_ticks(8);
    @(negedge CP50);
    checks++;
    if (run_en !== 1'b0) begin errors++; $display("FAIL hold_run_en_held: got %b want 0", run_en); end
    AdjH = 1'b0;
    wait_ticks(2);
    @(negedge CP50);
    checks++;
    if (run_en !== 1'b0) begin errors++; $display("FAIL hold_run_en_debr: got %b want 0", run_en); end
    wait_ticks(6);
    @(negedge CP50);
    checks++;
    if (run_en !== 1'b1) begin errors++; $display("FAIL hold_run_en_idle: got %b want 1", run_en); end
    settle();
    checks++;
    if (obs_q.size() != 1) begin
      errors++;
      $display("FAIL hold_count: got %0d pulses want 1", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0] !== 2'd0) begin errors++; $display("FAIL hold_code: got %0d want 0", obs_q[0]); end
      checks++;
      if (obs_tick_q[0] - t0 < DEB_MS || obs_tick_q[0] - t0 > DEB_MS + 1) begin
        errors++;
        $display("FAIL hold_latency: got %0d ticks want %0d..%0d", obs_tick_q[0] - t0, DEB_MS, DEB_MS + 1);
      end
    end
  endtask

  task automatic test_repeat();
    int n;
    clear_obs();
    DisplayA = 1'b1;
    run_en_low = 0;
    n = exp_pulses(30);
    for (int i = 0; i < n; i++) exp_q.push_back(2'd3);
    press(1'b0, 1'b1, 30);
    settle();
    DisplayA = 1'b0;
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL repeat_count: got %0d pulses want %0d", obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL repeat_code[%0d]: got %0d want %0d", i, obs_q[i], exp_q[i]);
        end
      end
      if (n >= 3) begin
        checks++;
        if (obs_cyc_q[1] - obs_cyc_q[0] != 2 * HOLD_MS) begin
          errors++;
          $display("FAIL repeat_hold_gap: got %0d cycles want %0d", obs_cyc_q[1] - obs_cyc_q[0], 2 * HOLD_MS);
        end
        checks++;
        if (obs_cyc_q[2] - obs_cyc_q[1] != 2 * REP_MS) begin
          errors++;
          $display("FAIL repeat_rep_gap: got %0d cycles want %0d", obs_cyc_q[2] - obs_cyc_q[1], 2 * REP_MS);
        end
      end
    end
    checks++;
    if (run_en_low != 0) begin errors++; $display("FAIL repeat_run_en: low for %0d cycles want 0", run_en_low); end
  endtask

  task automatic test_back_to_back();
    clear_obs();
    DisplayA = 1'b0;
    press(1'b1, 1'b1, 6);
    settle();
    checks++;
    if (obs_q.size() != 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d pulses want 2", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0] !== 2'd0 || obs_q[1] !== 2'd1) begin
        errors++;
        $display("FAIL b2b_order: got %0d,%0d want 0,1", obs_q[0], obs_q[1]);
      end
      checks++;
      if (obs_cyc_q[1] - obs_cyc_q[0] != 1) begin
        errors++;
        $display("FAIL b2b_spacing: got %0d cycles want 1", obs_cyc_q[1] - obs_cyc_q[0]);
      end
    end
  endtask

  task automatic test_target_latch();
    int n;
    clear_obs();
    DisplayA = 1'b0;
    align();
    AdjH = 1'b1;
    wait_ticks(8);
    @(negedge CP50);
    DisplayA = 1'b1;
    wait_ticks(14);
    @(negedge CP50);
    AdjH = 1'b0;
    settle();
    DisplayA = 1'b0;
    n = exp_pulses(22);
    checks++;
    if (obs_q.size() != n) begin
      errors++;
      $display("FAIL latch_count: got %0d pulses want %0d", obs_q.size(), n);
    end
    foreach (obs_q[i]) begin
      checks++;
      if (obs_q[i] !== 2'd0) begin errors++; $display("FAIL latch_code[%0d]: got %0d want 0", i, obs_q[i]); end
    end
  endtask

  task automatic test_tick_cont();
    clear_obs();
    tick_cont = 1'b1;
    DisplayA = 1'b1;
    press(1'b1, 1'b0, 8);
    settle();
    tick_cont = 1'b0;
    DisplayA = 1'b0;
    checks++;
    if (obs_q.size() != 1 || (obs_q.size() == 1 && obs_q[0] !== 2'd2)) begin
      errors++;
      $display("FAIL tick_cont: got %0d pulses (first code %0d) want 1 pulse code 2",
               obs_q.size(), obs_q.size() > 0 ? int'(obs_q[0]) : -1);
    end
  endtask

  task automatic test_reset_mid();
    int n0;
    int k;
    clear_obs();
    DisplayA = 1'b1;
    align();
    AdjM = 1'b1;
    wait_ticks(18);
    @(negedge CP50);
    nCR = 1'b0;
    #1;
    checks++;
    if ({time_inc_h, time_inc_m, alarm_inc_h, alarm_inc_m, sec_clr, adj_busy} !== 6'b0) begin
      errors++;
      $display("FAIL rstmid_outputs: got %b want 000000",
               {time_inc_h, time_inc_m, alarm_inc_h, alarm_inc_m, sec_clr, adj_busy});
    end
    repeat (3) @(negedge CP50);
    nCR = 1'b1;
    n0 = obs_q.size();
    wait_ticks(3);
    @(negedge CP50);
    checks++;
    if (obs_q.size() != n0) begin
      errors++;
      $display("FAIL rstmid_early: got %0d pulses within 3 ticks want 0", obs_q.size() - n0);
    end
    k = 0;
    while (obs_q.size() == n0 && k < 2 * (DEB_MS + 6)) begin
      @(negedge CP50);
      k++;
    end
    checks++;
    if (obs_q.size() == n0) begin
      errors++;
      $display("FAIL rstmid_fresh: got no pulse within %0d cycles want alarm_inc_m", k);
    end else begin
      checks++;
      if (obs_q[n0] !== 2'd3) begin errors++; $display("FAIL rstmid_code: got %0d want 3", obs_q[n0]); end
    end
    @(negedge CP50);
    AdjM = 1'b0;
    settle();
    DisplayA = 1'b0;
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int key_m, tgt, t, n;
      logic en_v;
      clear_obs();
      key_m = int'($urandom_range(0, 1));
      tgt = int'($urandom_range(0, 1));
      en_v = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 0) t = DEB_MS + 2 + int'($urandom_range(0, HOLD_MS - 4));
      else t = DEB_MS + HOLD_MS + 2 + REP_MS * int'($urandom_range(0, 3));
      n = exp_pulses(t);
      for (int i = 0; i < n; i++) exp_q.push_back(2'(tgt * 2 + key_m));
      EN = en_v;
      DisplayA = 1'(tgt);
      align();
      AdjH = (key_m == 0);
      AdjM = (key_m == 1);
      wait_ticks(t);
      @(negedge CP50);
      checks++;
      if (run_en !== (en_v & 1'(tgt))) begin
        errors++;
        $display("FAIL rand%0d_run_en: got %b want %b", it, run_en, en_v & 1'(tgt));
      end
      AdjH = 1'b0;
      AdjM = 1'b0;
      settle();
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        errors++;
        $display("FAIL rand%0d_count: got %0d pulses want %0d (t=%0d)", it, obs_q.size(), exp_q.size(), t);
      end else begin
        foreach (exp_q[i]) begin
          checks++;
          if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL rand%0d_code[%0d]: got %0d want %0d", it, i, obs_q[i], exp_q[i]);
          end
        end
      end
    end
    EN = 1'b1;
    DisplayA = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
`ifdef CLOCK_ADJ_AUTOREPEAT_EN
    autorep = 1'b1;
`endif
    test_reset();
    test_bounce();
    test_hold_single();
    test_repeat();
    test_back_to_back();
    test_target_latch();
    test_tick_cont();
    test_reset_mid();
    test_random();
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL pulse_rules: %0d cycles with >1 inc pulse or sec_clr != time_inc_m, want 0", viol);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clock_adj_ctrl.md
Name: clock_adj_ctrl

Overview:
- Adjust-key controller for the MainClock time chain and alarm registers.
- Synchronises and debounces the raw AdjH/AdjM keys and converts presses into single-cycle increment pulses, with auto-repeat while a key is held.
- Routes each pulse to either the time counters or the alarm registers, selected by DisplayA.
- Gates the time-chain count enable while the time is being adjusted.

Parameters:
- DEB_MS, 20, debounce interval in tick_ms strobes (press and release); legal range 1..255
- HOLD_MS, 600, hold time before auto-repeat starts, in tick_ms strobes; legal range 1..1023
- REP_MS, 200, auto-repeat period, in tick_ms strobes; legal range 1..1023

Ports:
- CP50  in  1  system clock, rising edge
- nCR  in  1  asynchronous active-low reset
- tick_ms  in  1  1 kHz strobe from prescaler, one CP50 cycle wide
- EN  in  1  global run enable
- DisplayA  in  1  adjust target: 0 = time counters, 1 = alarm registers
- AdjH  in  1  raw hour key, active high, asynchronous
- AdjM  in  1  raw minute key, active high, asynchronous
- time_inc_h  out  1  one-cycle pulse: increment time hours
- time_inc_m  out  1  one-cycle pulse: increment time minutes
- alarm_inc_h  out  1  one-cycle pulse: increment alarm hours
- alarm_inc_m  out  1  one-cycle pulse: increment alarm minutes
- sec_clr  out  1  one-cycle pulse: clear the seconds counter; coincident with time_inc_m
- run_en  out  1  count enable for the time chain
- adj_busy  out  1  high while either key FSM is outside IDLE

Behaviour:
- Reset: nCR low clears all state asynchronously. Key FSMs go to IDLE, counters to 0, all pulse outputs to 0, adj_busy to 0. run_en = EN during reset.
- Synchroniser: AdjH/AdjM pass through a 2-flop synchroniser. The FSMs see only synchronised values.
- Key FSM (one instance per key), states IDLE, DEB_P, HELD, REPEAT, DEB_R:
  - IDLE: sync key = 1 -> DEB_P, counter cleared.
  - DEB_P: counter increments on tick_ms. Key = 0 -> IDLE. Counter reaches DEB_MS-1 on a tick with key still 1 -> HELD. The entry into HELD raises a request and latches the target (DisplayA).
  - HELD: counts ticks. Key = 0 -> DEB_R. HOLD_MS ticks elapse -> REPEAT, raising a request.
  - REPEAT: raises a request every REP_MS ticks. Key = 0 -> DEB_R.
  - DEB_R: key must stay 0 for DEB_MS ticks -> IDLE. Key = 1 before then -> previous state (HELD or REPEAT) with its counter preserved and no new request.
- Target latch: the target is captured at DEB_P->HELD. A DisplayA change while in HELD, REPEAT or DEB_R has no effect until the next press.
- Arbitration: each key has a one-deep pending flag.
  - At most one inc pulse is issued per CP50 cycle.
  - Hour has priority. If both are pending in the same cycle, the hour pulse issues first and the minute pulse issues the next cycle.
  - A new request while the flag is already set is dropped.
- Pulse mapping:
  - H request -> time_inc_h or alarm_inc_h, according to the latched target.
  - M request -> time_inc_m plus sec_clr (target 0), or alarm_inc_m (target 1).
- Latency: first pulse appears DEB_MS ticks after the synchronised rising edge, plus 1 cycle for registering.
- run_en = EN & ~(some key FSM in HELD/REPEAT/DEB_R with latched target 0). It is combinational from registered state.
- Boundary conditions:
  - tick_ms held high continuously is legal; every cycle then counts as a tick.
  - EN = 0 does not block pulses.
  - Reset mid-press aborts without emitting any pulse.
  - Counter widths are sized from the parameters; no wrap occurs within legal ranges.

Optional Feature:
- Macro: CLOCK_ADJ_AUTOREPEAT_EN.
- Defined: auto-repeat as specified.
- Undefined: the REPEAT state is not built. HELD remains until release and emits exactly one pulse per press; HOLD_MS and REP_MS are ignored.

Decomposition:
- Shared package clock_pkg holds:
  - key_state_t enum {IDLE, DEB_P, HELD, REPEAT, DEB_R}
  - TGT_TIME/TGT_ALARM constants
  - a width helper for the tick counters
- Natural sub-module: clock_adj_key_fsm (synchroniser, debounce, hold/repeat, pending flag), instantiated twice. The top level contains the arbiter, target mapping and run_en.

Test Plan (DEB_MS=4, HOLD_MS=10, REP_MS=5, tick_ms every 2nd cycle):
- AdjM pulsed high for 3 ticks (bounce), DisplayA=0 -> no pulses; adj_busy returns to 0; run_en stays 1.
- AdjH held 8 ticks, DisplayA=0 -> exactly one time_inc_h about 4 ticks after the edge; run_en=0 from HELD until 4 ticks after release.
- AdjM held 30 ticks, DisplayA=1, macro defined -> alarm_inc_m at the debounce point, then at +10 and every 5 ticks after (5 pulses total). sec_clr never asserts and run_en stays 1. With the macro undefined -> exactly 1 pulse.
- AdjH and AdjM rise in the same cycle, DisplayA=0 -> time_inc_h in cycle N, time_inc_m plus sec_clr in cycle N+1.
- AdjH pressed with DisplayA=0, DisplayA switched to 1 mid-hold -> repeats remain on time_inc_h.
- nCR asserted during REPEAT -> all outputs 0 immediately; after release with the key still held, a fresh debounce is required before the next pulse.
